io_port_unit: RTL and testbench
===============================

// Module: io_port_unit
// PURPOSE
//  I/O responder for the soft microprocessor: services the control unit's
//  io_write_en / io_read_en strobes (OUTPUT / INPUT instructions) against a
//  small port map. Drives LEDs, samples switches, queues TX bytes in a FIFO
//  and holds one RX byte. rd_data feeds rf_w_data_src = 2'b00 of the
//  register-file write mux.
// PARAMETERS
//  DATA_W       8  data width of every port
//  PORT_W       8  port_id width (instruction field)
//  FIFO_DEPTH   4  TX FIFO entries, power of two, >= 2
//  SYNC_STAGES  2  switch-input synchroniser flops, >= 2
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  reset        in   1       synchronous, active-low (0 = reset)
//  io_write_en  in   1       one-cycle write strobe from control unit
//  io_read_en   in   1       read level; high for the whole INPUT instruction
//  port_id      in   PORT_W  selected port, valid whenever a strobe/level is high
//  wr_data      in   DATA_W  OUTPUT data from register file read port
//  rd_data      out  DATA_W  INPUT data to register-file write mux
//  led_out      out  DATA_W  port 0x00 write register
//  sw_in        in   DATA_W  asynchronous switches, port 0x00 read
//  tx_data      out  DATA_W  TX FIFO head
//  tx_valid     out  1       TX FIFO not empty
//  tx_ready     in   1       peripheral accepts tx_data this cycle
//  rx_data      in   DATA_W  incoming byte
//  rx_valid     in   1       rx_data valid
//  rx_ready     out  1       RX holding register empty
//  tx_overflow  out  1       sticky: TX push dropped because FIFO was full
// BEHAVIOUR
//  Reset (reset==0 at a clock edge): led_out=0, rd_data=0, tx_valid=0,
//   FIFO pointers/count=0, RX holder empty, rx_ready=0, tx_overflow=0,
//   synchroniser flops=0. Strobes are ignored while reset==0. rx_ready=1 from
//   the first cycle after reset release while the holder is empty.
//  Port map, write (io_write_en==1):
//   0x00 led_out <= wr_data at that edge.
//   0x01 push wr_data to TX FIFO. If full, drop the byte and set tx_overflow.
//   0x03 clear tx_overflow; data ignored. Other ports: no effect.
//  Port map, read: 0x00 synchronised sw_in; 0x01 RX holder byte (0 if empty);
//   0x02 status {zeros, rx_full(bit1), tx_full(bit0)}. Other ports read 0x00.
//  Read timing: on the first cycle io_read_en==1 (rising edge detected against
//   a registered copy), rd_data <= mux(port_id). rd_data is valid one cycle
//   later and held stable until the next rising edge of io_read_en.
//  RX pop: on the falling edge of io_read_en, if the last read port was 0x01,
//   empty the holder. rx_ready=1 the next cycle.
//  RX fill: when rx_valid && rx_ready, holder <= rx_data and rx_ready=0 the
//   next cycle. A pop and fill can never occur in the same cycle.
//  TX FIFO: tx_data = head, tx_valid = count!=0, pop on tx_valid && tx_ready.
//   There is no fall-through: a push into an empty FIFO gives tx_valid=1 on the
//   next cycle. A push and pop in the same cycle when full: both succeed,
//   count unchanged, no overflow. A push and pop when count==1: count stays 1.
//   Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.
//  sw_in passes through SYNC_STAGES flops. A change is visible to a read that
//   starts SYNC_STAGES cycles later.
//  A reset mid-operation discards all FIFO contents and the RX byte, with no
//   pop handshake to the peripheral.
// STRUCTURE
//  Shared package io_port_pkg contains: PORT_LED=0x00, PORT_UART=0x01,
//   PORT_STATUS=0x02, PORT_CLR=0x03, STAT_TX_FULL=0, STAT_RX_FULL=1.
//  One sub-module, io_tx_fifo (DATA_W, FIFO_DEPTH; push/pop/full/empty/head,
//   same clk/reset). Port decode, RX holder and synchroniser stay top-level.
// TESTING
//  1 Reset: hold reset=0 for 3 cycles with io_write_en=1, port 0x00, data 0xFF
//    -> led_out=0x00, tx_valid=0, rd_data=0x00, tx_overflow=0.
//  2 LED: write port 0x00 with 0xA5 -> led_out=0xA5 next cycle, held after
//    10 idle cycles. Write port 0x07 -> led_out is still 0xA5.
//  3 TX overflow: tx_ready=0, push 0x11..0x15 to port 0x01 -> read of port 0x02
//    gives 0x01, tx_overflow=1. Set tx_ready=1 -> tx_data 0x11,0x12,0x13,0x14
//    on consecutive cycles, then tx_valid=0. Write port 0x03 -> tx_overflow=0.
//  4 RX: rx_data=0x3C with rx_valid for 1 cycle -> rx_ready=0. Read port 0x02
//    gives 0x02. Hold a read of port 0x01 for 4 cycles -> rd_data=0x3C, stable.
//    One cycle after io_read_en falls, rx_ready=1 and a status read gives 0x00.
//  5 Sync: sw_in 0x00->0x0F. A read of port 0x00 started 1 cycle later gives
//    0x00. A read started SYNC_STAGES cycles later gives 0x0F.
//  6 Full push+pop and mid-op reset: fill the FIFO to 4, then push 0x99 with
//    tx_ready=1 -> no overflow, 0x99 is the last byte out. Refill to 3, assert
//    reset -> tx_valid=0 and status 0x00 after release.

Source files
------------

// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants for the soft-CPU I/O port responder.
// Port map addresses and status-register bit positions.
package io_port_pkg;

    localparam int PORT_LED    = 'h00;
    localparam int PORT_UART   = 'h01;
    localparam int PORT_STATUS = 'h02;
    localparam int PORT_CLR    = 'h03;

    localparam int STAT_TX_FULL = 0;
    localparam int STAT_RX_FULL = 1;

endpackage

// File: rtl/io_tx_fifo.sv
// io_tx_fifo: registered TX byte queue, no fall-through.
// A push while full is accepted only if a pop happens in the same cycle.
module io_tx_fifo
    import io_port_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // Next-state: pop frees a slot that a same-cycle push may reuse.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // State registers; reset discards contents by clearing pointers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: port-mapped LED, switch, TX FIFO and RX holder.
// Services OUTPUT/INPUT instruction strobes from the control unit.
module io_port_unit
    import io_port_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PORT_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_write_en,
    input  logic              io_read_en,
    input  logic [PORT_W-1:0] port_id,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] led_out,
    input  logic [DATA_W-1:0] sw_in,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              tx_overflow
);

    logic [DATA_W-1:0] led_q, led_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
    logic              rx_full_q, rx_full_d;
    logic              rx_rdy_q, rx_rdy_d;
    logic              ovf_q, ovf_d;
    logic              rd_en_q, rd_en_d;
    logic [PORT_W-1:0] last_port_q, last_port_d;
    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] sync_d [SYNC_STAGES];

    logic sel_led, sel_uart, sel_stat, sel_clr;
    logic tx_push, tx_pop, tx_full, tx_empty;
    logic rd_rise, rd_fall;
    logic [DATA_W-1:0] rd_mux;

    assign sel_led  = (port_id == PORT_W'(PORT_LED));
    assign sel_uart = (port_id == PORT_W'(PORT_UART));
    assign sel_stat = (port_id == PORT_W'(PORT_STATUS));
    assign sel_clr  = (port_id == PORT_W'(PORT_CLR));

    assign tx_push = io_write_en && sel_uart;
    assign tx_pop  = !tx_empty && tx_ready;
    assign rd_rise = io_read_en && !rd_en_q;
    assign rd_fall = !io_read_en && rd_en_q;

    assign rd_data     = rd_q;
    assign led_out     = led_q;
    assign tx_valid    = !tx_empty;
    assign rx_ready    = rx_rdy_q;
    assign tx_overflow = ovf_q;

    io_tx_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tx_push),
        .push_data(wr_data),
        .pop      (tx_pop),
        .full     (tx_full),
        .empty    (tx_empty),
        .head     (tx_data)
    );

    // Read-port multiplexer; unmapped ports read as zero.
    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            sel_led:  rd_mux = sync_q[SYNC_STAGES-1];
            sel_uart: rd_mux = rx_full_q ? rx_byte_q : '0;
            sel_stat: begin
                rd_mux[STAT_TX_FULL] = tx_full;
                rd_mux[STAT_RX_FULL] = rx_full_q;
            end
            default: ;
        endcase
    end

    // Next-state for port registers, RX holder and switch synchroniser.
    always_comb begin
        led_d       = led_q;
        rd_d        = rd_q;
        rx_byte_d   = rx_byte_q;
        rx_full_d   = rx_full_q;
        ovf_d       = ovf_q;
        last_port_d = last_port_q;
        rd_en_d     = io_read_en;
        if (rd_rise) begin
            rd_d        = rd_mux;
            last_port_d = port_id;
        end
        if (rd_fall && last_port_q == PORT_W'(PORT_UART)) begin
            rx_full_d = 1'b0;
        end
        if (rx_valid && rx_rdy_q) begin
            rx_full_d = 1'b1;
            rx_byte_d = rx_data;
        end
        rx_rdy_d = !rx_full_d;
        if (io_write_en && sel_led) begin
            led_d = wr_data;
        end
        if (io_write_en && sel_clr) begin
            ovf_d = 1'b0;
        end
        if (tx_push && tx_full && !tx_pop) begin
            ovf_d = 1'b1;
        end
        sync_d[0] = sw_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_q       <= '0;
            rd_q        <= '0;
            rx_byte_q   <= '0;
            rx_full_q   <= 1'b0;
            rx_rdy_q    <= 1'b0;
            ovf_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            last_port_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            led_q       <= led_d;
            rd_q        <= rd_d;
            rx_byte_q   <= rx_byte_d;
            rx_full_q   <= rx_full_d;
            rx_rdy_q    <= rx_rdy_d;
            ovf_q       <= ovf_d;
            rd_en_q     <= rd_en_d;
            last_port_q <= last_port_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

endmodule

// File: tb/tb_io_port_unit.sv
// tb_io_port_unit: directed and random checks of io_port_unit.
// Outputs compared every cycle against a queue-based port model.
module tb_io_port_unit;

    localparam int DATA_W = 8;
    localparam int PORT_W = 8;
    localparam int DEPTH  = 4;
    localparam int SYNC   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              io_write_en;
    logic              io_read_en;
    logic [PORT_W-1:0] port_id;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] led_out;
    logic [DATA_W-1:0] sw_in;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              tx_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0] m_led, m_rd, m_rx_byte, m_last_port;
    bit         m_rx_full, m_rx_rdy, m_ovf, m_prev_rd;
    logic [7:0] m_tx[$];
    logic [7:0] m_sw[SYNC];

    io_port_unit #(
        .DATA_W     (DATA_W),
        .PORT_W     (PORT_W),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .io_write_en(io_write_en),
        .io_read_en (io_read_en),
        .port_id    (port_id),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .led_out    (led_out),
        .sw_in      (sw_in),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, want %02h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] p);
        logic [7:0] v;
        v = 8'h00;
        case (p)
            8'h00: v = m_sw[SYNC-1];
            8'h01: v = m_rx_full ? m_rx_byte : 8'h00;
            8'h02: v = {6'b0, m_rx_full, m_tx.size() == DEPTH};
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    task automatic model_step();
        bit rise, fall;
        if (!reset) begin
            m_led = 0; m_rd = 0; m_rx_byte = 0; m_last_port = 0;
            m_rx_full = 0; m_rx_rdy = 0; m_ovf = 0; m_prev_rd = 0;
            m_tx.delete();
            for (int i = 0; i < SYNC; i++) m_sw[i] = 0;
            return;
        end
        rise = io_read_en && !m_prev_rd;
        fall = !io_read_en && m_prev_rd;
        if (rise) begin
            m_rd = m_read(port_id);
            m_last_port = port_id;
        end
        if (fall && m_last_port == 8'h01) m_rx_full = 0;
        if (rx_valid && m_rx_rdy) begin
            m_rx_full = 1;
            m_rx_byte = rx_data;
        end
        m_rx_rdy = !m_rx_full;
        if (m_tx.size() > 0 && tx_ready) void'(m_tx.pop_front());
        if (io_write_en && port_id == 8'h01) begin
            if (m_tx.size() < DEPTH) m_tx.push_back(wr_data);
            else m_ovf = 1;
        end
        if (io_write_en && port_id == 8'h00) m_led = wr_data;
        if (io_write_en && port_id == 8'h03) m_ovf = 0;
        m_prev_rd = io_read_en;
        for (int i = SYNC - 1; i > 0; i--) m_sw[i] = m_sw[i-1];
        m_sw[0] = sw_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m_led", led_out, m_led);
        chk("m_rd", rd_data, m_rd);
        chk("m_txv", 8'(tx_valid), 8'(m_tx.size() != 0));
        if (m_tx.size() != 0) chk("m_txd", tx_data, m_tx[0]);
        chk("m_rxrdy", 8'(rx_ready), 8'(m_rx_rdy));
        chk("m_ovf", 8'(tx_overflow), 8'(m_ovf));
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        io_write_en = 1; port_id = p; wr_data = d;
        tick();
        io_write_en = 0;
    endtask

    task automatic rd_start(input logic [7:0] p);
        io_read_en = 1; port_id = p;
        tick();
    endtask

    task automatic rd_end();
        io_read_en = 0;
        tick();
    endtask

    initial begin
        logic [7:0] last;
        reset = 0; io_write_en = 0; io_read_en = 0; port_id = 0;
        wr_data = 0; sw_in = 0; tx_ready = 0; rx_data = 0;
        rx_valid = 0;

        // 1 reset with a write strobe asserted
        io_write_en = 1; port_id = 8'h00; wr_data = 8'hFF;
        repeat (3) tick();
        chk("rst_led", led_out, 8'h00);
        chk("rst_txv", 8'(tx_valid), 8'h00);
        chk("rst_rd", rd_data, 8'h00);
        chk("rst_ovf", 8'(tx_overflow), 8'h00);
        chk("rst_rxrdy", 8'(rx_ready), 8'h00);
        io_write_en = 0; reset = 1;
        tick();
        chk("rel_rxrdy", 8'(rx_ready), 8'h01);

        // 2 LED register
        wr(8'h00, 8'hA5);
        chk("led_wr", led_out, 8'hA5);
        repeat (10) tick();
        chk("led_hold", led_out, 8'hA5);
        wr(8'h07, 8'h5A);
        chk("led_unmapped", led_out, 8'hA5);

        // 3 TX overflow and drain
        for (int i = 0; i < 5; i++) wr(8'h01, 8'(8'h11 + i));
        chk("ovf_set", 8'(tx_overflow), 8'h01);
        rd_start(8'h02);
        chk("stat_txfull", rd_data, 8'h01);
        rd_end();
        tx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_v", 8'(tx_valid), 8'h01);
            chk("drain_d", tx_data, 8'(8'h11 + i));
            tick();
        end
        chk("drain_empty", 8'(tx_valid), 8'h00);
        tx_ready = 0;
        wr(8'h03, 8'hFF);
        chk("ovf_clr", 8'(tx_overflow), 8'h00);

        // 4 RX holder
        rx_data = 8'h3C; rx_valid = 1;
        tick();
        rx_valid = 0; rx_data = 8'h77;
        chk("rx_busy", 8'(rx_ready), 8'h00);
        rd_start(8'h02);
        chk("stat_rxfull", rd_data, 8'h02);
        rd_end();
        rd_start(8'h01);
        chk("rx_rd", rd_data, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rx_rd_hold", rd_data, 8'h3C);
        end
        rd_end();
        chk("rx_free", 8'(rx_ready), 8'h01);
        chk("rx_rd_after", rd_data, 8'h3C);
        rd_start(8'h02);
        chk("stat_clear", rd_data, 8'h00);
        rd_end();

        // 5 switch synchroniser latency
        sw_in = 8'h0F;
        tick();
        rd_start(8'h00);
        chk("sw_early", rd_data, 8'h00);
        rd_end();
        sw_in = 8'h00;
        repeat (4) tick();
        sw_in = 8'h0F;
        repeat (SYNC) tick();
        rd_start(8'h00);
        chk("sw_late", rd_data, 8'h0F);
        rd_end();

        // 6 full push+pop, then reset mid-operation
        for (int i = 0; i < 4; i++) wr(8'h01, 8'($urandom));
        tx_ready = 1;
        wr(8'h99 & 8'h01, 8'h99);
        chk("pp_no_ovf", 8'(tx_overflow), 8'h00);
        last = 8'h00;
        for (int i = 0; i < 10 && tx_valid; i++) begin
            last = tx_data;
            tick();
        end
        chk("pp_drained", 8'(tx_valid), 8'h00);
        chk("pp_last", last, 8'h99);
        tx_ready = 0;
        for (int i = 0; i < 3; i++) wr(8'h01, 8'($urandom));
        chk("refill_v", 8'(tx_valid), 8'h01);
        reset = 0;
        tick();
        reset = 1;
        tick();
        chk("mid_rst_txv", 8'(tx_valid), 8'h00);
        rd_start(8'h02);
        chk("mid_rst_stat", rd_data, 8'h00);
        rd_end();

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            reset       = ($urandom_range(0, 99) != 0);
            io_write_en = ($urandom_range(0, 2) == 0);
            port_id     = 8'($urandom_range(0, 4));
            wr_data     = 8'($urandom);
            if ($urandom_range(0, 3) == 0) io_read_en = !io_read_en;
            rx_valid    = ($urandom_range(0, 2) == 0);
            rx_data     = 8'($urandom);
            tx_ready    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) sw_in = 8'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
